// File: rtl/lvl_queue_ctrl_if.sv
// lvl_queue_ctrl_if: press handshake plus queue/car status bundle for the elevator queue controller
interface lvl_queue_ctrl_if;
  logic       press_valid;
  logic [1:0] pressed_lvl;
  logic       press_accept;
  logic [7:0] queue;
  logic [2:0] tail;
  logic [1:0] cur_lvl;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic       empty;
  logic       full;
  modport master (
    output press_valid, pressed_lvl,
    input  press_accept, queue, tail, cur_lvl, moving, dir_up, door_open, empty, full
  );
  modport slave (
    input  press_valid, pressed_lvl,
    output press_accept, queue, tail, cur_lvl, moving, dir_up, door_open, empty, full
  );
endinterface

// File: rtl/lvl_queue_ctrl.sv
// lvl_queue_ctrl: 4-entry duplicate-free elevator request queue and the car-motion FSM serving its head
module lvl_queue_ctrl #(
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lvl_queue_ctrl_if.slave  bus
);
  localparam int MW = MOVE_CYCLES > 1 ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = DOOR_CYCLES > 1 ? $clog2(DOOR_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t          state_q, state_d;
  logic [7:0]      queue_q, queue_d;
  logic [2:0]      tail_q, tail_d;
  logic [1:0]      cur_q, cur_d;
  logic            dir_q, dir_d;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            pop, dup, accept, q_empty, q_full;
  logic [1:0]      head, step_lvl, push_idx;
  assign head    = queue_q[1:0];
  assign q_empty = tail_q == 3'd0;
  assign q_full  = tail_q == 3'd4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      queue_q <= '0;
      tail_q  <= '0;
      cur_q   <= '0;
      dir_q   <= 1'b0;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      queue_q <= queue_d;
      tail_q  <= tail_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      mcnt_q  <= mcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end
  // head only changes on a pop, so it stays fixed for the whole trip
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    dir_d    = dir_q;
    mcnt_d   = mcnt_q;
    dcnt_d   = dcnt_q;
    pop      = 1'b0;
    step_lvl = dir_q ? cur_q + 2'd1 : cur_q - 2'd1;
    case (state_q)
      IDLE: if (!q_empty) begin
        if (head == cur_q) begin
          state_d = DOOR;
          pop     = 1'b1;
        end else begin
          state_d = MOVE;
          dir_d   = head > cur_q;
          mcnt_d  = '0;
        end
      end
      MOVE: if (mcnt_q == MW'(MOVE_CYCLES - 1)) begin
        mcnt_d = '0;
        cur_d  = step_lvl;
        if (step_lvl == head) begin
          state_d = DOOR;
          pop     = 1'b1;
        end else dir_d = head > step_lvl;
      end else mcnt_d = mcnt_q + 1'b1;
      DOOR: if (dcnt_q == DW'(DOOR_CYCLES - 1)) begin
        state_d = IDLE;
        dcnt_d  = '0;
      end else dcnt_d = dcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // dup looks at pre-pop contents, so a press matching the departing head is dropped
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < tail_q && queue_q[2*i +: 2] == bus.pressed_lvl) dup = 1'b1;
    accept   = bus.press_valid & ~dup & (~q_full | pop);
    push_idx = pop ? 2'(tail_q - 3'd1) : tail_q[1:0];
    queue_d  = pop ? {2'b00, queue_q[7:2]} : queue_q;
    if (accept) queue_d[{push_idx, 1'b0} +: 2] = bus.pressed_lvl;
    tail_d   = tail_q + {2'b00, accept} - {2'b00, pop};
  end
  always_comb begin
    bus.press_accept = accept;
    bus.queue        = queue_q;
    bus.tail         = tail_q;
    bus.cur_lvl      = cur_q;
    bus.moving       = state_q == MOVE;
    bus.dir_up       = dir_q;
    bus.door_open    = state_q == DOOR;
    bus.empty        = q_empty;
    bus.full         = q_full;
  end
endmodule
